// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: services data- and instruction-cache misses by issuing a
// burst of word reads to main memory, steering the returned words into the
// owning cache, and writing that cache's tag once the block is complete.
// The data cache has fixed priority over the instruction cache. Blocks are
// 16-byte aligned (eight 16-bit words), so only address bits [3:1] vary.

module cache_fill_ctrl #(
   parameter int MEM_LATENCY = 4,   // nominal memory latency; informational only
   parameter int BLOCK_WORDS = 8    // 16-bit words per cache block
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        d_miss,
   input  logic [15:0] d_miss_addr,
   input  logic        i_miss,
   input  logic [15:0] i_miss_addr,
   output logic        mem_enable,
   output logic [15:0] mem_addr,
   input  logic        mem_data_valid,
   input  logic [15:0] mem_data_in,
   output logic [15:0] fill_addr,
   output logic [15:0] fill_data,
   output logic        d_data_wr,
   output logic        i_data_wr,
   output logic        d_write_tag,
   output logic        i_write_tag,
   output logic        d_stall,
   output logic        i_stall,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      WTAG = 2'd2
   } state_t;

   localparam logic OWNER_D = 1'b0;
   localparam logic OWNER_I = 1'b1;

   // Counter limits sized to the 4-bit issue/receive counters.
   localparam logic [3:0] BLK_CNT  = 4'(BLOCK_WORDS);
   localparam logic [3:0] LAST_CNT = 4'(BLOCK_WORDS - 1);

   state_t      state_q,     state_d;
   logic        owner_q,     owner_d;
   logic [11:0] base_q,      base_d;       // block address bits [15:4]
   logic [3:0]  issue_cnt_q, issue_cnt_d;
   logic [3:0]  rcv_cnt_q,   rcv_cnt_d;

   logic        issuing;
   logic        accept;
   logic [2:0]  issue_idx;
   logic [2:0]  rcv_idx;

   // Latency is a property of the memory, not of this controller; the low
   // miss-address bits are masked off by block alignment.
   logic unused_inputs;
   assign unused_inputs = ^{d_miss_addr[3:0], i_miss_addr[3:0]} ^ (MEM_LATENCY > 0);

   // State register with synchronous active-high reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWNER_D;
         base_q      <= '0;
         issue_cnt_q <= '0;
         rcv_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         base_q      <= base_d;
         issue_cnt_q <= issue_cnt_d;
         rcv_cnt_q   <= rcv_cnt_d;
      end
   end

   // Read issue and word acceptance qualifiers; counters saturate at the block size.
   always_comb begin
      issuing   = (state_q == FILL) && (issue_cnt_q < BLK_CNT);
      accept    = (state_q == FILL) && mem_data_valid && (rcv_cnt_q < BLK_CNT);
      // Once all reads are issued the address holds on the last word.
      issue_idx = (issue_cnt_q < BLK_CNT) ? issue_cnt_q[2:0] : LAST_CNT[2:0];
      rcv_idx   = (rcv_cnt_q   < BLK_CNT) ? rcv_cnt_q[2:0]   : LAST_CNT[2:0];
   end

   // Next-state logic: grant in IDLE, count reads and returns in FILL, one tag cycle.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      owner_d     = owner_q;
      base_d      = base_q;
      issue_cnt_d = issue_cnt_q;
      rcv_cnt_d   = rcv_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (d_miss) begin
               state_d     = FILL;
               owner_d     = OWNER_D;
               base_d      = d_miss_addr[15:4];
               issue_cnt_d = '0;
               rcv_cnt_d   = '0;
            end else if (i_miss) begin
               state_d     = FILL;
               owner_d     = OWNER_I;
               base_d      = i_miss_addr[15:4];
               issue_cnt_d = '0;
               rcv_cnt_d   = '0;
            end
         end
         FILL: begin
            if (issuing) begin
               issue_cnt_d = issue_cnt_q + 4'd1;
            end
            if (accept) begin
               rcv_cnt_d = rcv_cnt_q + 4'd1;
               if (rcv_cnt_q == LAST_CNT) begin
                  state_d = WTAG;
               end
            end
         end
         WTAG: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode: strobes go only to the owning cache; stalls include the raw miss.
   always_comb begin
      busy        = (state_q != IDLE);
      mem_enable  = issuing;
      mem_addr    = {base_q, issue_idx, 1'b0};
      fill_addr   = {base_q, rcv_idx, 1'b0};
      fill_data   = mem_data_in;
      d_data_wr   = accept && (owner_q == OWNER_D);
      i_data_wr   = accept && (owner_q == OWNER_I);
      d_write_tag = (state_q == WTAG) && (owner_q == OWNER_D);
      i_write_tag = (state_q == WTAG) && (owner_q == OWNER_I);
      d_stall     = d_miss | (busy && (owner_q == OWNER_D));
      i_stall     = i_miss | (busy && (owner_q == OWNER_I));
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed testbench for cache_fill_ctrl. Cycle 0 is the IDLE cycle in which a
// miss is presented; cycle 1 is the first FILL cycle. Inputs are driven 1 time
// unit after the rising edge and outputs sampled 1 time unit later.

module tb_cache_fill_ctrl;

   localparam int MEM_LATENCY = 4;
   localparam int BLOCK_WORDS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        d_miss;
   logic [15:0] d_miss_addr;
   logic        i_miss;
   logic [15:0] i_miss_addr;
   logic        mem_enable;
   logic [15:0] mem_addr;
   logic        mem_data_valid;
   logic [15:0] mem_data_in;
   logic [15:0] fill_addr;
   logic [15:0] fill_data;
   logic        d_data_wr;
   logic        i_data_wr;
   logic        d_write_tag;
   logic        i_write_tag;
   logic        d_stall;
   logic        i_stall;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   cache_fill_ctrl #(
      .MEM_LATENCY (MEM_LATENCY),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .d_miss         (d_miss),
      .d_miss_addr    (d_miss_addr),
      .i_miss         (i_miss),
      .i_miss_addr    (i_miss_addr),
      .mem_enable     (mem_enable),
      .mem_addr       (mem_addr),
      .mem_data_valid (mem_data_valid),
      .mem_data_in    (mem_data_in),
      .fill_addr      (fill_addr),
      .fill_data      (fill_data),
      .d_data_wr      (d_data_wr),
      .i_data_wr      (i_data_wr),
      .d_write_tag    (d_write_tag),
      .i_write_tag    (i_write_tag),
      .d_stall        (d_stall),
      .i_stall        (i_stall),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Everything idle: no strobes, no memory request, addresses cleared.
   task automatic check_quiet(input string tag);
      check({tag, "_busy"},    32'(busy), 32'd0);
      check({tag, "_men"},     32'(mem_enable), 32'd0);
      check({tag, "_maddr"},   32'(mem_addr), 32'h0);
      check({tag, "_faddr"},   32'(fill_addr), 32'h0);
      check({tag, "_strobes"}, 32'({d_data_wr, i_data_wr, d_write_tag, i_write_tag}), 32'd0);
   endtask

   // Runs one fill from its first FILL cycle through the return to IDLE.
   // The owner's miss is dropped in cycle 1; the other miss is left as driven.
   // Returns arrive MEM_LATENCY cycles after the first request, either every
   // cycle or every other cycle, and keep arriving into WTAG and IDLE.
   task automatic fill_seq(input bit own, input logic [15:0] base, input bit gapped);
      int          words = 0;
      int          tagc  = -1;
      bit          done  = 1'b0;
      logic        exp_busy, exp_en, exp_wr, exp_tag;
      logic        own_wr, oth_wr, own_tag, oth_tag, own_stall, oth_stall, oth_miss;
      logic [15:0] exp_addr;
      for (int c = 1; c < 60 && !done; c++) begin
         tick();
         if (c == 1) begin
            if (own) i_miss = 1'b0;
            else     d_miss = 1'b0;
         end
         mem_data_valid = (c >= 1 + MEM_LATENCY) &&
                          (!gapped || (((c - 1 - MEM_LATENCY) % 2) == 0));
         mem_data_in    = 16'hC000 + 16'(c * 16'h0101);
         #1;
         exp_en   = (c <= BLOCK_WORDS);
         exp_addr = base + 16'(2 * ((c - 1 < BLOCK_WORDS - 1) ? c - 1 : BLOCK_WORDS - 1));
         exp_wr   = 1'b0;
         exp_tag  = 1'b0;
         if (words < BLOCK_WORDS) begin
            exp_busy = 1'b1;
            exp_wr   = mem_data_valid;
         end else if (c == tagc) begin
            exp_busy = 1'b1;
            exp_tag  = 1'b1;
         end else begin
            exp_busy = 1'b0;
            done     = 1'b1;
         end
         own_wr    = own ? i_data_wr   : d_data_wr;
         oth_wr    = own ? d_data_wr   : i_data_wr;
         own_tag   = own ? i_write_tag : d_write_tag;
         oth_tag   = own ? d_write_tag : i_write_tag;
         own_stall = own ? i_stall     : d_stall;
         oth_stall = own ? d_stall     : i_stall;
         oth_miss  = own ? d_miss      : i_miss;
         check($sformatf("c%0d_busy", c),      32'(busy), 32'(exp_busy));
         check($sformatf("c%0d_men", c),       32'(mem_enable), 32'(exp_en));
         check($sformatf("c%0d_maddr", c),     32'(mem_addr), 32'(exp_addr));
         check($sformatf("c%0d_own_wr", c),    32'(own_wr), 32'(exp_wr));
         check($sformatf("c%0d_oth_wr", c),    32'(oth_wr), 32'd0);
         check($sformatf("c%0d_own_tag", c),   32'(own_tag), 32'(exp_tag));
         check($sformatf("c%0d_oth_tag", c),   32'(oth_tag), 32'd0);
         check($sformatf("c%0d_own_stall", c), 32'(own_stall), 32'(exp_busy));
         check($sformatf("c%0d_oth_stall", c), 32'(oth_stall), 32'(oth_miss));
         if (exp_wr) begin
            check($sformatf("c%0d_faddr", c), 32'(fill_addr), 32'(base + 16'(2 * words)));
            check($sformatf("c%0d_fdata", c), 32'(fill_data), 32'(mem_data_in));
            words++;
            if (words == BLOCK_WORDS) tagc = c + 1;
         end
      end
      check("fill_completed", 32'(done), 32'd1);
      mem_data_valid = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      d_miss         = 1'b0;
      d_miss_addr    = 16'h0;
      i_miss         = 1'b0;
      i_miss_addr    = 16'h0;
      mem_data_valid = 1'b0;
      mem_data_in    = 16'h0;

      // Reset, with a miss and a spurious return present while held.
      tick();
      d_miss         = 1'b1;
      d_miss_addr    = 16'hABCD;
      mem_data_valid = 1'b1;
      tick();
      #1;
      check_quiet("reset");
      d_miss         = 1'b0;
      mem_data_valid = 1'b0;

      // D fill of block 0x1230 at the nominal latency.
      tick();
      rst         = 1'b0;
      d_miss      = 1'b1;
      d_miss_addr = 16'h1236;
      #1;
      check("d0_busy",    32'(busy), 32'd0);
      check("d0_dstall",  32'(d_stall), 32'd1);
      check("d0_istall",  32'(i_stall), 32'd0);
      check("d0_men",     32'(mem_enable), 32'd0);
      fill_seq(1'b0, 16'h1230, 1'b0);

      // Spurious return in IDLE: no strobe, read address still on the last word.
      tick();
      mem_data_valid = 1'b1;
      #1;
      check("idle_spur_dwr", 32'(d_data_wr), 32'd0);
      check("idle_spur_iwr", 32'(i_data_wr), 32'd0);
      check("idle_maddr",    32'(mem_addr), 32'h123E);
      check("idle_busy",     32'(busy), 32'd0);
      mem_data_valid = 1'b0;

      // Simultaneous misses: D block 0x8880 first, then I block 0x0450.
      tick();
      d_miss      = 1'b1;
      d_miss_addr = 16'h8882;
      i_miss      = 1'b1;
      i_miss_addr = 16'h0458;
      #1;
      check("sim0_dstall", 32'(d_stall), 32'd1);
      check("sim0_istall", 32'(i_stall), 32'd1);
      fill_seq(1'b0, 16'h8880, 1'b0);
      fill_seq(1'b1, 16'h0450, 1'b0);

      // Gapped returns into the top block of the address space (no carry out).
      tick();
      d_miss      = 1'b1;
      d_miss_addr = 16'hFFFF;
      fill_seq(1'b0, 16'hFFF0, 1'b1);

      // Reset after the third returned word abandons the fill.
      tick();
      d_miss      = 1'b1;
      d_miss_addr = 16'h7774;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) d_miss = 1'b0;
         mem_data_valid = (c >= 5) && (c <= 7);
         mem_data_in    = 16'h3300 + 16'(c);
         if (c == 8) rst = 1'b1;
         #1;
         check($sformatf("rst_c%0d_busy", c),  32'(busy), 32'd1);
         check($sformatf("rst_c%0d_maddr", c), 32'(mem_addr), 32'(16'h7770 + 16'(2 * ((c < 8) ? c - 1 : 7))));
         check($sformatf("rst_c%0d_dwr", c),   32'(d_data_wr), 32'(mem_data_valid));
         check($sformatf("rst_c%0d_tag", c),   32'({d_write_tag, i_write_tag}), 32'd0);
      end
      mem_data_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check_quiet("post_rst");
      check("post_rst_dstall", 32'(d_stall), 32'd0);
      d_miss      = 1'b1;
      d_miss_addr = 16'h7774;
      fill_seq(1'b0, 16'h7770, 1'b0);

      // Trailing IDLE cycle: no tag write after the restarted fill completes.
      tick();
      #1;
      check("final_tags", 32'({d_write_tag, i_write_tag}), 32'd0);
      check("final_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
